// File: rtl/si5340_cfg_sequencer_pkg.sv
// Shared encodings and helpers for the Si5340 configuration sequencer.
package si5340_cfg_sequencer_pkg;

    typedef logic [3:0] state_t;

    localparam state_t StIdle  = 4'd0;
    localparam state_t StFetch = 4'd1;
    localparam state_t StLatch = 4'd2;
    localparam state_t StPage  = 4'd3;
    localparam state_t StReg   = 4'd4;
    localparam state_t StIssue = 4'd5;
    localparam state_t StWait  = 4'd6;
    localparam state_t StNext  = 4'd7;
    localparam state_t StPause = 4'd8;
    localparam state_t StDone  = 4'd9;
    localparam state_t StErr   = 4'd10;

    // Position of the byte currently being sent within a 3-byte write transaction.
    typedef enum logic [1:0] {ByteAddr, ByteReg, ByteData} byte_sel_e;

    localparam logic [7:0] PAGE_REG = 8'h01;

    function automatic logic [7:0] write_addr(input logic [6:0] slave);
        return {slave, 1'b0};
    endfunction

    function automatic int unsigned pause_cycles(input int unsigned clk_freq,
                                                 input int unsigned pause_ms);
        return (clk_freq / 1000) * pause_ms;
    endfunction

endpackage

// File: rtl/si5340_cfg_sequencer_if.sv
// Byte-level command/response port between the sequencer and an I2C master.
interface si5340_cfg_sequencer_if #(
    parameter int unsigned DATA_WIDTH = 8
) ();
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_start;
    logic                  cmd_stop;
    logic [DATA_WIDTH-1:0] cmd_data;
    logic                  rsp_valid;
    logic                  rsp_nack;

    modport master (
        output cmd_valid, cmd_start, cmd_stop, cmd_data,
        input  cmd_ready, rsp_valid, rsp_nack
    );

    modport slave (
        input  cmd_valid, cmd_start, cmd_stop, cmd_data,
        output cmd_ready, rsp_valid, rsp_nack
    );
endinterface

// File: rtl/si5340_cfg_sequencer_delay_timer.sv
// One-shot cycle timer: start_i arms it, expire_o pulses in the CYCLES-th armed cycle.
module si5340_cfg_sequencer_delay_timer #(
    parameter int unsigned CYCLES = 10
) (
    input  logic clk_i,
    input  logic arst_i,
    input  logic start_i,
    output logic expire_o
);
    localparam int unsigned CntW = $clog2(CYCLES + 1) + 1;
    // CYCLES == 0 still expires in the first armed cycle.
    localparam logic [CntW-1:0] CntLast = CntW'((CYCLES == 0) ? 0 : CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            run_q, run_d;

    assign expire_o = run_q & (cnt_q == CntLast);

    always_comb begin
        cnt_d = cnt_q;
        run_d = run_q;
        if (start_i) begin
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            if (expire_o) begin
                run_d = 1'b0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end
endmodule

// File: rtl/si5340_cfg_sequencer.sv
// Walks the {page,reg,data} config ROM and issues Si5340 I2C writes, inserting page
// writes on page change, pausing after the preamble and retrying NACKed transactions.
module si5340_cfg_sequencer
    import si5340_cfg_sequencer_pkg::*;
#(
    parameter int unsigned MEM_WIDTH      = 24,
    parameter int unsigned WORD_NUMBER    = 326,
    parameter int unsigned DATA_WIDTH     = 8,
    parameter int unsigned CLK_FREQ       = 125_000_000,
    parameter logic [6:0]  SLAVE_ADDR     = 7'h74,
    parameter int unsigned PREAMBLE_WORDS = 3,
    parameter int unsigned PAUSE_MS       = 300,
    parameter int unsigned MAX_RETRY      = 3
) (
    input  logic                           clk_i,
    input  logic                           arst_i,
    input  logic                           start_i,
    output logic [$clog2(WORD_NUMBER)-1:0] rom_addr_o,
    input  logic [MEM_WIDTH-1:0]           rom_data_i,
    si5340_cfg_sequencer_if.master         i2c_io,
    output logic                           busy_o,
    output logic                           done_o,
    output logic                           error_o
);
    localparam int unsigned AddrW       = $clog2(WORD_NUMBER);
    localparam int unsigned RetryW      = $clog2(MAX_RETRY + 1) + 1;
    localparam int unsigned PauseCycles = pause_cycles(CLK_FREQ, PAUSE_MS);
    localparam logic [AddrW-1:0]  LastIdx     = AddrW'(WORD_NUMBER - 1);
    localparam logic [AddrW-1:0]  PreambleIdx = AddrW'(PREAMBLE_WORDS - 1);
    localparam logic [RetryW-1:0] RetryMax    = RetryW'(MAX_RETRY);

    state_t               state_q, state_d;
    logic [AddrW-1:0]     idx_q, idx_d;
    logic [MEM_WIDTH-1:0] word_q, word_d;
    logic [7:0]           page_q, page_d;
    logic                 page_valid_q, page_valid_d;
    logic                 is_page_q, is_page_d;
    byte_sel_e            byte_q, byte_d;
    logic [RetryW-1:0]    retry_q, retry_d;
    logic                 busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic                 timer_start, timer_expire;
    logic [7:0]           tx_byte;

    si5340_cfg_sequencer_delay_timer #(
        .CYCLES(PauseCycles)
    ) u_pause_timer (
        .clk_i   (clk_i),
        .arst_i  (arst_i),
        .start_i (timer_start),
        .expire_o(timer_expire)
    );

    always_comb begin
        state_d      = state_q;
        idx_d        = idx_q;
        word_d       = word_q;
        page_d       = page_q;
        page_valid_d = page_valid_q;
        is_page_d    = is_page_q;
        byte_d       = byte_q;
        retry_d      = retry_q;
        busy_d       = busy_q;
        done_d       = done_q;
        error_d      = error_q;
        timer_start  = 1'b0;
        case (state_q)
            StIdle, StDone, StErr: begin
                if (start_i) begin
                    done_d       = 1'b0;
                    error_d      = 1'b0;
                    page_valid_d = 1'b0;
                    idx_d        = '0;
                    retry_d      = '0;
                    busy_d       = 1'b1;
                    state_d      = StFetch;
                end
            end
            StFetch: state_d = StLatch;
            StLatch: begin
                word_d  = rom_data_i;
                state_d = (!page_valid_q || rom_data_i[MEM_WIDTH-1 -: 8] != page_q) ? StPage
                                                                                   : StReg;
            end
            StPage, StReg: begin
                is_page_d = (state_q == StPage);
                byte_d    = ByteAddr;
                state_d   = StIssue;
            end
            StIssue: if (i2c_io.cmd_ready) state_d = StWait;
            StWait: begin
                if (i2c_io.rsp_valid) begin
                    if (i2c_io.rsp_nack) begin
                        if (retry_q == RetryMax) begin
                            error_d = 1'b1;
                            busy_d  = 1'b0;
                            state_d = StErr;
                        end else begin
                            retry_d = retry_q + 1'b1;
                            byte_d  = ByteAddr;
                            state_d = StIssue;
                        end
                    end else if (byte_q != ByteData) begin
                        byte_d  = (byte_q == ByteAddr) ? ByteReg : ByteData;
                        state_d = StIssue;
                    end else begin
                        retry_d = '0;
                        if (is_page_q) begin
                            page_d       = word_q[MEM_WIDTH-1 -: 8];
                            page_valid_d = 1'b1;
                            state_d      = StReg;
                        end else begin
                            state_d = StNext;
                        end
                    end
                end
            end
            StNext: begin
                // Last word wins over the preamble check so the index never wraps.
                if (idx_q == LastIdx) begin
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
                    state_d = StDone;
                end else if (idx_q == PreambleIdx) begin
                    timer_start = 1'b1;
                    state_d     = StPause;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StFetch;
                end
            end
            StPause: begin
                if (timer_expire) begin
                    idx_d   = idx_q + 1'b1;
                    state_d = StFetch;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        tx_byte = write_addr(SLAVE_ADDR);
        unique case (byte_q)
            ByteAddr: tx_byte = write_addr(SLAVE_ADDR);
            ByteReg:  tx_byte = is_page_q ? PAGE_REG : word_q[15:8];
            ByteData: tx_byte = is_page_q ? word_q[MEM_WIDTH-1 -: 8] : word_q[7:0];
            default:  tx_byte = write_addr(SLAVE_ADDR);
        endcase
    end

    assign rom_addr_o       = idx_q;
    assign i2c_io.cmd_valid = (state_q == StIssue);
    assign i2c_io.cmd_start = i2c_io.cmd_valid & (byte_q == ByteAddr);
    assign i2c_io.cmd_stop  = i2c_io.cmd_valid & (byte_q == ByteData);
    assign i2c_io.cmd_data  = i2c_io.cmd_valid ? DATA_WIDTH'(tx_byte) : '0;
    assign busy_o           = busy_q;
    assign done_o           = done_q;
    assign error_o          = error_q;

    always_ff @(posedge clk_i or posedge arst_i) begin
        if (arst_i) begin
            state_q      <= StIdle;
            idx_q        <= '0;
            word_q       <= '0;
            page_q       <= '0;
            page_valid_q <= 1'b0;
            is_page_q    <= 1'b0;
            byte_q       <= ByteAddr;
            retry_q      <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            page_q       <= page_d;
            page_valid_q <= page_valid_d;
            is_page_q    <= is_page_d;
            byte_q       <= byte_d;
            retry_q      <= retry_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            error_q      <= error_d;
        end
    end
endmodule
